// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_port_arbiter
// Purpose  : Arbiter/sequencer for the single lookup port of the L2 cache
//            model. Picks one of L1 / snoop / maintenance requests, issues it
//            to the cache and waits for the completion pulse before issuing
//            the next one. Snoops beat L1 but L1 cannot lose more than
//            starveLimit consecutive grants while it is waiting. A watchdog
//            drops an op the cache never completes.
// Ports    : clk, resetN (sync, active low)
//            l1Valid/l1Ready/l1Op/l1Address           L1 request channel
//            snoopValid/snoopReady/snoopOp/snoopAddress snoop channel
//            maintValid/maintReady/maintOp             maintenance channel
//            cacheValid/cacheSource/cacheOp/cacheAddress issued operation
//            cacheDone                                 completion pulse
//            busy, timeoutError, l1Grants, snoopGrants status/statistics
// Revision : 1.0 - initial release
// ============================================================================
module l2_port_arbiter #(
  parameter int addressSize   = 32,
  parameter int starveLimit   = 4,
  parameter int timeoutCycles = 1024
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   l1Valid,
  output logic                   l1Ready,
  input  logic [1:0]             l1Op,
  input  logic [addressSize-1:0] l1Address,
  input  logic                   snoopValid,
  output logic                   snoopReady,
  input  logic [1:0]             snoopOp,
  input  logic [addressSize-1:0] snoopAddress,
  input  logic                   maintValid,
  output logic                   maintReady,
  input  logic                   maintOp,
  output logic                   cacheValid,
  output logic [1:0]             cacheSource,
  output logic [1:0]             cacheOp,
  output logic [addressSize-1:0] cacheAddress,
  input  logic                   cacheDone,
  output logic                   busy,
  output logic                   timeoutError,
  output logic [31:0]            l1Grants,
  output logic [31:0]            snoopGrants
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SRC_L1    = 2'd0;
  localparam logic [1:0] SRC_SNOOP = 2'd1;
  localparam logic [1:0] SRC_MAINT = 2'd2;

  localparam int STARVE_W = $clog2(starveLimit + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(starveLimit);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  // Watchdog counts completed WAIT cycles, so it only ever needs to reach
  // timeoutCycles-1 before firing.
  localparam int WD_W = $clog2(timeoutCycles);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeoutCycles - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  state_t                state;
  state_t                state_next;
  logic [STARVE_W-1:0]   starve_count;
  logic [WD_W-1:0]       wd_count;
  logic                  win_l1;
  logic                  win_snoop;
  logic                  win_maint;
  logic                  accept;
  logic                  done_hit;
  logic                  wd_fire;
  logic                  clear_done;

  // Priority: maintenance, then a starved L1, then snoop, then L1.
  always_comb begin
    win_maint = 1'b0;
    win_snoop = 1'b0;
    win_l1    = 1'b0;
    if (maintValid) begin
      win_maint = 1'b1;
    end else if (l1Valid && (starve_count == STARVE_MAX)) begin
      win_l1 = 1'b1;
    end else if (snoopValid) begin
      win_snoop = 1'b1;
    end else if (l1Valid) begin
      win_l1 = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    l1Ready    = 1'b0;
    snoopReady = 1'b0;
    maintReady = 1'b0;
    done_hit   = 1'b0;
    wd_fire    = 1'b0;
    case (state)
      IDLE: begin
        // Readies are gated by resetN so nothing is handshaken during reset.
        if (resetN) begin
          l1Ready    = win_l1;
          snoopReady = win_snoop;
          maintReady = win_maint;
          if (win_l1 || win_snoop || win_maint) begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // A done on the watchdog's final edge wins over the timeout.
        if (cacheDone) begin
          done_hit   = 1'b1;
          state_next = IDLE;
        end else if (wd_count == WD_LAST) begin
          wd_fire    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Each ready is only raised for a valid winner, so any ready is an accept.
  assign accept     = l1Ready || snoopReady || maintReady;
  assign clear_done = done_hit && (cacheSource == SRC_MAINT) && (cacheOp == 2'd0);
  assign cacheValid = (state == WAIT);
  assign busy       = (state == WAIT);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= IDLE;
      cacheSource  <= 2'd0;
      cacheOp      <= 2'd0;
      cacheAddress <= '0;
      starve_count <= '0;
      wd_count     <= '0;
      timeoutError <= 1'b0;
      l1Grants     <= 32'd0;
      snoopGrants  <= 32'd0;
    end else begin
      state <= state_next;

      if (accept) begin
        wd_count <= '0;
        if (win_maint) begin
          cacheSource  <= SRC_MAINT;
          cacheOp      <= {1'b0, maintOp};
          cacheAddress <= '0;
        end else if (win_snoop) begin
          cacheSource  <= SRC_SNOOP;
          cacheOp      <= snoopOp;
          cacheAddress <= snoopAddress;
          if (snoopGrants != 32'hFFFF_FFFF) begin
            snoopGrants <= snoopGrants + 32'd1;
          end
          if (l1Valid && (starve_count != STARVE_MAX)) begin
            starve_count <= starve_count + STARVE_ONE;
          end
        end else begin
          cacheSource  <= SRC_L1;
          cacheOp      <= l1Op;
          cacheAddress <= l1Address;
          starve_count <= '0;
          if (l1Grants != 32'hFFFF_FFFF) begin
            l1Grants <= l1Grants + 32'd1;
          end
        end
      end

      if ((state == WAIT) && !cacheDone && !wd_fire) begin
        wd_count <= wd_count + WD_ONE;
      end

      if (wd_fire) begin
        timeoutError <= 1'b1;
      end

      if (clear_done) begin
        l1Grants     <= 32'd0;
        snoopGrants  <= 32'd0;
        starve_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_port_arbiter
// Purpose  : Self-checking bench for l2_port_arbiter. Directed scenarios plus
//            a randomized run compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_port_arbiter;

  localparam int AW = 32;
  localparam int SL = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetN;
  logic          l1Valid;
  logic          l1Ready;
  logic [1:0]    l1Op;
  logic [AW-1:0] l1Address;
  logic          snoopValid;
  logic          snoopReady;
  logic [1:0]    snoopOp;
  logic [AW-1:0] snoopAddress;
  logic          maintValid;
  logic          maintReady;
  logic          maintOp;
  logic          cacheValid;
  logic [1:0]    cacheSource;
  logic [1:0]    cacheOp;
  logic [AW-1:0] cacheAddress;
  logic          cacheDone;
  logic          busy;
  logic          timeoutError;
  logic [31:0]   l1Grants;
  logic [31:0]   snoopGrants;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_port_arbiter #(
    .addressSize  (AW),
    .starveLimit  (SL),
    .timeoutCycles(TO)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .l1Valid     (l1Valid),
    .l1Ready     (l1Ready),
    .l1Op        (l1Op),
    .l1Address   (l1Address),
    .snoopValid  (snoopValid),
    .snoopReady  (snoopReady),
    .snoopOp     (snoopOp),
    .snoopAddress(snoopAddress),
    .maintValid  (maintValid),
    .maintReady  (maintReady),
    .maintOp     (maintOp),
    .cacheValid  (cacheValid),
    .cacheSource (cacheSource),
    .cacheOp     (cacheOp),
    .cacheAddress(cacheAddress),
    .cacheDone   (cacheDone),
    .busy        (busy),
    .timeoutError(timeoutError),
    .l1Grants    (l1Grants),
    .snoopGrants (snoopGrants)
  );

  // ---------------- transaction-level reference model ----------------
  bit            m_busy;     // an op is outstanding at the cache
  int            m_src;
  int            m_op;
  logic [AW-1:0] m_addr;
  int            m_losses;   // snoop wins suffered by a waiting L1 (capped)
  longint        m_l1g;
  longint        m_sg;
  bit            m_to;
  int            m_waited;   // cycles spent waiting without completion

  // Returns who should be granted now: -1 none, 0 L1, 1 snoop, 2 maint.
  function automatic int pick();
    if (!resetN || m_busy) return -1;
    if (maintValid) return 2;
    if (l1Valid && m_losses == SL) return 0;
    if (snoopValid) return 1;
    if (l1Valid) return 0;
    return -1;
  endfunction

  function automatic longint sat_inc(longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Advance one clock: update the model from the inputs present at the edge,
  // then step past the edge.
  task automatic tick();
    int w;
    w = pick();
    if (!resetN) begin
      m_busy = 0; m_src = 0; m_op = 0; m_addr = '0; m_losses = 0;
      m_l1g = 0; m_sg = 0; m_to = 0; m_waited = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1;
        m_src = w;
        m_waited = 0;
        if (w == 0) begin
          m_op = int'(l1Op); m_addr = l1Address; m_l1g = sat_inc(m_l1g); m_losses = 0;
        end else if (w == 1) begin
          m_op = int'(snoopOp); m_addr = snoopAddress; m_sg = sat_inc(m_sg);
          if (l1Valid && m_losses < SL) m_losses = m_losses + 1;
        end else begin
          m_op = int'(maintOp); m_addr = '0;
        end
      end
    end else begin
      if (cacheDone) begin
        m_busy = 0;
        if (m_src == 2 && m_op == 0) begin
          m_l1g = 0; m_sg = 0; m_losses = 0;
        end
      end else begin
        m_waited = m_waited + 1;
        if (m_waited == TO) begin
          m_busy = 0;
          m_to = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    l1Valid = 0; snoopValid = 0; maintValid = 0; cacheDone = 0;
  endtask

  task automatic issue_and_done();
    tick();
    cacheDone = 1;
    tick();
    cacheDone = 0;
  endtask

  task automatic do_reset();
    resetN = 0;
    tick();
    resetN = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetN = 0;
    l1Valid = 1; snoopValid = 1; maintValid = 1;
    #1;
    checks++;
    if ({l1Ready, snoopReady, maintReady} !== 3'b000)
      begin errors++; $display("FAIL reset_readies: got %b want 000", {l1Ready, snoopReady, maintReady}); end
    tick();
    tick();
    checks++;
    if ({cacheValid, busy, timeoutError, cacheSource, cacheOp} !== 7'd0 || cacheAddress !== '0)
      begin errors++; $display("FAIL reset_outputs: valid=%b busy=%b to=%b src=%0d op=%0d addr=%h want all 0",
                              cacheValid, busy, timeoutError, cacheSource, cacheOp, cacheAddress); end
    checks++;
    if (l1Grants !== 32'd0 || snoopGrants !== 32'd0)
      begin errors++; $display("FAIL reset_counters: l1=%0d snoop=%0d want 0 0", l1Grants, snoopGrants); end
    idle_inputs();
    resetN = 1;
    tick();
  endtask

  task automatic test_single_l1();
    l1Valid = 1; l1Op = 2'd0; l1Address = 32'h0000_1040;
    #1;
    checks++;
    if (l1Ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", l1Ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cacheValid !== 1'b1 || busy !== 1'b1 || cacheSource !== 2'd0 || cacheOp !== 2'd0 || cacheAddress !== 32'h0000_1040)
        begin errors++; $display("FAIL single_hold[%0d]: valid=%b busy=%b src=%0d op=%0d addr=%h want 1 1 0 0 00001040",
                                i, cacheValid, busy, cacheSource, cacheOp, cacheAddress); end
      checks++;
      if (l1Ready !== 1'b0) begin errors++; $display("FAIL single_ready_wait[%0d]: got %b want 0", i, l1Ready); end
      if (i == 2) cacheDone = 1;
      tick();
    end
    cacheDone = 0;
    #1;
    checks++;
    if (cacheValid !== 1'b0 || l1Grants !== 32'd1)
      begin errors++; $display("FAIL single_done: valid=%b l1Grants=%0d want 0 1", cacheValid, l1Grants); end
    checks++;
    if (l1Ready !== 1'b1) begin errors++; $display("FAIL single_next_ready: got %b want 1", l1Ready); end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    longint l1_start, s_start;
    l1_start = m_l1g; s_start = m_sg;
    l1Valid = 1; snoopValid = 1;
    l1Op = 2'd2; l1Address = 32'hA000_0000;
    snoopOp = 2'd3; snoopAddress = 32'h5000_0000;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({l1Ready, snoopReady} !== ((exp_order[i] == 0) ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL starve_ready[%0d]: l1Ready=%b snoopReady=%b want grant %0d",
                                i, l1Ready, snoopReady, exp_order[i]); end
      tick();
      checks++;
      if (cacheSource !== 2'(exp_order[i]))
        begin errors++; $display("FAIL starve_order[%0d]: src=%0d want %0d", i, cacheSource, exp_order[i]); end
      cacheDone = 1;
      tick();
      cacheDone = 0;
    end
    checks++;
    if (snoopGrants !== 32'(s_start + 8) || l1Grants !== 32'(l1_start + 2))
      begin errors++; $display("FAIL starve_counts: snoop=%0d l1=%0d want %0d %0d",
                              snoopGrants, l1Grants, s_start + 8, l1_start + 2); end
    idle_inputs();
    tick();
  endtask

  task automatic test_maint_priority();
    logic [31:0] l1_before, s_before;
    l1_before = l1Grants; s_before = snoopGrants;
    maintValid = 1; maintOp = 1'b1;
    snoopValid = 1; snoopOp = 2'd1; snoopAddress = 32'h0BAD_F00D;
    l1Valid = 1; l1Op = 2'd1; l1Address = 32'h1234_5678;
    tick();
    maintValid = 0;
    checks++;
    if (cacheSource !== 2'd2 || cacheOp !== 2'd1 || cacheAddress !== 32'd0)
      begin errors++; $display("FAIL maint_first: src=%0d op=%0d addr=%h want 2 1 0", cacheSource, cacheOp, cacheAddress); end
    cacheDone = 1; tick(); cacheDone = 0;
    checks++;
    if (l1Grants !== l1_before || snoopGrants !== s_before)
      begin errors++; $display("FAIL maint_print_counters: l1=%0d snoop=%0d want %0d %0d",
                              l1Grants, snoopGrants, l1_before, s_before); end
    tick();
    snoopValid = 0;
    checks++;
    if (cacheSource !== 2'd1 || cacheOp !== 2'd1 || cacheAddress !== 32'h0BAD_F00D)
      begin errors++; $display("FAIL maint_second: src=%0d op=%0d addr=%h want 1 1 0badf00d", cacheSource, cacheOp, cacheAddress); end
    cacheDone = 1; tick(); cacheDone = 0;
    tick();
    l1Valid = 0;
    checks++;
    if (cacheSource !== 2'd0 || cacheOp !== 2'd1 || cacheAddress !== 32'h1234_5678)
      begin errors++; $display("FAIL maint_third: src=%0d op=%0d addr=%h want 0 1 12345678", cacheSource, cacheOp, cacheAddress); end
    cacheDone = 1; tick(); cacheDone = 0;
    idle_inputs();
  endtask

  task automatic test_clear();
    do_reset();
    l1Valid = 1; l1Op = 2'd3; l1Address = 32'h0000_0100;
    for (int i = 0; i < 3; i++) issue_and_done();
    l1Valid = 0; snoopValid = 1; snoopOp = 2'd0; snoopAddress = 32'h0000_0200;
    for (int i = 0; i < 2; i++) issue_and_done();
    snoopValid = 0;
    checks++;
    if (l1Grants !== 32'd3 || snoopGrants !== 32'd2)
      begin errors++; $display("FAIL clear_pre: l1=%0d snoop=%0d want 3 2", l1Grants, snoopGrants); end
    maintValid = 1; maintOp = 1'b0;
    tick();
    maintValid = 0;
    checks++;
    if (l1Grants !== 32'd3 || snoopGrants !== 32'd2 || cacheOp !== 2'd0 || cacheSource !== 2'd2)
      begin errors++; $display("FAIL clear_wait: l1=%0d snoop=%0d src=%0d op=%0d want 3 2 2 0",
                              l1Grants, snoopGrants, cacheSource, cacheOp); end
    cacheDone = 1; tick(); cacheDone = 0;
    checks++;
    if (l1Grants !== 32'd0 || snoopGrants !== 32'd0)
      begin errors++; $display("FAIL clear_done: l1=%0d snoop=%0d want 0 0", l1Grants, snoopGrants); end
  endtask

  task automatic test_watchdog();
    do_reset();
    l1Valid = 1; l1Op = 2'd0; l1Address = 32'hDEAD_0000;
    tick();
    l1Valid = 0;
    for (int i = 1; i < TO; i++) tick();
    checks++;
    if (cacheValid !== 1'b1 || timeoutError !== 1'b0)
      begin errors++; $display("FAIL wd_before: valid=%b to=%b want 1 0", cacheValid, timeoutError); end
    tick();
    checks++;
    if (cacheValid !== 1'b0 || busy !== 1'b0 || timeoutError !== 1'b1 || l1Grants !== 32'd1)
      begin errors++; $display("FAIL wd_fire: valid=%b busy=%b to=%b l1=%0d want 0 0 1 1",
                              cacheValid, busy, timeoutError, l1Grants); end
    l1Valid = 1; l1Address = 32'hDEAD_0004;
    #1;
    checks++;
    if (l1Ready !== 1'b1) begin errors++; $display("FAIL wd_next_ready: got %b want 1", l1Ready); end
    tick();
    l1Valid = 0;
    checks++;
    if (cacheValid !== 1'b1 || cacheAddress !== 32'hDEAD_0004 || timeoutError !== 1'b1)
      begin errors++; $display("FAIL wd_next_accept: valid=%b addr=%h to=%b want 1 dead0004 1",
                              cacheValid, cacheAddress, timeoutError); end
    cacheDone = 1; tick(); cacheDone = 0;
    // Completion on the very edge the watchdog would fire.
    do_reset();
    l1Valid = 1;
    tick();
    l1Valid = 0;
    for (int i = 1; i < TO; i++) tick();
    cacheDone = 1; tick(); cacheDone = 0;
    checks++;
    if (timeoutError !== 1'b0 || cacheValid !== 1'b0)
      begin errors++; $display("FAIL wd_done_wins: to=%b valid=%b want 0 0", timeoutError, cacheValid); end
  endtask

  task automatic test_reset_mid_wait();
    snoopValid = 1; snoopOp = 2'd2; snoopAddress = 32'hCAFE_0000;
    tick();
    snoopValid = 0;
    tick();
    resetN = 0; l1Valid = 1; snoopValid = 1; maintValid = 1;
    #1;
    checks++;
    if ({l1Ready, snoopReady, maintReady} !== 3'b000)
      begin errors++; $display("FAIL rstwait_readies: got %b want 000", {l1Ready, snoopReady, maintReady}); end
    tick();
    checks++;
    if (cacheValid !== 1'b0 || busy !== 1'b0 || cacheSource !== 2'd0 || cacheOp !== 2'd0 ||
        cacheAddress !== '0 || snoopGrants !== 32'd0 || l1Grants !== 32'd0)
      begin errors++; $display("FAIL rstwait_state: valid=%b busy=%b src=%0d op=%0d addr=%h l1=%0d snoop=%0d want all 0",
                              cacheValid, busy, cacheSource, cacheOp, cacheAddress, l1Grants, snoopGrants); end
    idle_inputs();
    resetN = 1;
    cacheDone = 1;
    tick();
    cacheDone = 0;
    checks++;
    if (cacheValid !== 1'b0 || timeoutError !== 1'b0 || snoopGrants !== 32'd0)
      begin errors++; $display("FAIL rstwait_stale_done: valid=%b to=%b snoop=%0d want 0 0 0",
                              cacheValid, timeoutError, snoopGrants); end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 600; i++) begin
      resetN       = ($urandom_range(0, 149) != 0);
      l1Valid      = $urandom_range(0, 1) == 1;
      snoopValid   = $urandom_range(0, 1) == 1;
      maintValid   = $urandom_range(0, 9) == 0;
      l1Op         = 2'($urandom_range(0, 3));
      snoopOp      = 2'($urandom_range(0, 3));
      maintOp      = $urandom_range(0, 1) == 1;
      l1Address    = $urandom;
      snoopAddress = $urandom;
      // Second half completes rarely so the watchdog gets exercised.
      cacheDone    = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      #1;
      w = pick();
      checks++;
      if ({maintReady, snoopReady, l1Ready} !== {w == 2, w == 1, w == 0})
        begin errors++; $display("FAIL rand_ready[%0d]: m/s/l=%b%b%b want winner %0d",
                                i, maintReady, snoopReady, l1Ready, w); end
      tick();
      checks++;
      if (cacheValid !== m_busy || busy !== m_busy || timeoutError !== m_to)
        begin errors++; $display("FAIL rand_status[%0d]: valid=%b busy=%b to=%b want %b %b %b",
                                i, cacheValid, busy, timeoutError, m_busy, m_busy, m_to); end
      checks++;
      if (cacheSource !== 2'(m_src) || cacheOp !== 2'(m_op) || cacheAddress !== m_addr)
        begin errors++; $display("FAIL rand_payload[%0d]: src=%0d op=%0d addr=%h want %0d %0d %h",
                                i, cacheSource, cacheOp, cacheAddress, m_src, m_op, m_addr); end
      checks++;
      if (l1Grants !== m_l1g[31:0] || snoopGrants !== m_sg[31:0])
        begin errors++; $display("FAIL rand_counters[%0d]: l1=%0d snoop=%0d want %0d %0d",
                                i, l1Grants, snoopGrants, m_l1g, m_sg); end
    end
    idle_inputs();
    resetN = 1;
  endtask

  initial begin
    resetN = 0;
    idle_inputs();
    l1Op = '0; l1Address = '0; snoopOp = '0; snoopAddress = '0; maintOp = 1'b0;
    m_busy = 0; m_src = 0; m_op = 0; m_addr = '0; m_losses = 0;
    m_l1g = 0; m_sg = 0; m_to = 0; m_waited = 0;
    test_reset();
    test_single_l1();
    test_starvation();
    test_maint_priority();
    test_clear();
    test_watchdog();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Arbiter and sequencer for the single lookup port of the L2 cache model. It accepts L1-side requests, snooped shared-bus operations and maintenance commands from the trace front end through valid/ready handshakes. It issues exactly one operation at a time to the cache and waits for the cache's completion pulse before issuing the next. It also enforces snoop-over-L1 priority with a starvation bound, a completion watchdog, and grant statistics.

## Interface
- addressSize, 32, width of all address buses
- starveLimit, 4, consecutive snoop grants that L1 may lose while valid before L1 is forced (legal range ≥1)
- timeoutCycles, 1024, maximum cycles in WAIT before the watchdog fires (legal range ≥2)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- resetN  in  1  synchronous, active-low reset
- l1Valid / l1Ready  in / out  1 / 1  L1 request handshake
- l1Op  in  2  0=data read, 1=data write, 2=instruction read (3 reserved, accepted, passed through)
- l1Address  in  addressSize  L1 request address
- snoopValid / snoopReady  in / out  1 / 1  snoop handshake
- snoopOp  in  2  0=invalidate, 1=read, 2=write, 3=read-with-intent-to-modify
- snoopAddress  in  addressSize  snooped address
- maintValid / maintReady  in / out  1 / 1  maintenance handshake
- maintOp  in  1  0=clear cache and reset states, 1=print contents
- cacheValid  out  1  operation presented to cache
- cacheSource  out  2  0=L1, 1=snoop, 2=maintenance
- cacheOp  out  2  op code of the granted source (maintOp zero-extended)
- cacheAddress  out  addressSize  granted address (0 for maintenance)
- cacheDone  in  1  single-cycle completion from cache
- busy  out  1  high in WAIT
- timeoutError  out  1  sticky watchdog flag
- l1Grants, snoopGrants  out  32 / 32  saturating grant counters

## Operation
- FSM states: IDLE, WAIT.
- IDLE: winner chosen combinationally from the valids.
  - maintValid wins first.
  - Otherwise, if l1Valid and starveCount==starveLimit, L1 wins.
  - Otherwise snoopValid wins.
  - Otherwise l1Valid wins.
- Only the winner's ready is high, and only in IDLE with resetN high. Every ready is 0 in WAIT.
- Accept (winner valid & ready):
  - Register source, op and address onto the cache outputs.
  - Go to WAIT.
  - Increment the matching grant counter (maintenance increments neither). Counters saturate at 0xFFFFFFFF.
- starveCount:
  - Increments, saturating at starveLimit, on a snoop grant while l1Valid is high.
  - Clears to 0 on an L1 grant.
  - Unchanged otherwise.
- WAIT:
  - cacheValid=1, busy=1; cache outputs held stable.
  - On cacheDone=1: go to IDLE.
  - If the completed op was a maintenance clear (maintOp 0), also zero l1Grants, snoopGrants and starveCount on that edge.
- Watchdog:
  - Counter clears on entry to WAIT and increments each WAIT cycle without cacheDone.
  - At timeoutCycles, set timeoutError, go to IDLE, and drop the op without any counter rollback.
  - timeoutError clears only by reset.
- cacheDone sampled in IDLE is ignored.
- Input payloads may change freely while valid is low. They must be stable only on the accept cycle.

## Timing
- Reset (resetN low at an edge), from any state including mid-WAIT:
  - state IDLE; cacheValid, busy, timeoutError = 0.
  - cacheSource, cacheOp, cacheAddress = 0.
  - l1Grants, snoopGrants, starveCount, watchdog = 0.
  - All readies 0 while resetN is low.
  - A pending op is abandoned and no done is awaited.
- Accept at edge N → cacheValid high in cycle N+1.
- cacheDone high at edge M (M ≥ N+1, including the first WAIT cycle) → cacheValid low in cycle M+1, and a new accept is possible at edge M+1.
- Back-to-back throughput: one op per (done latency + 1) cycles.
- Simultaneous valids are resolved only by the priority rule; losers hold valid and are not accepted.
- Watchdog fires at the edge ending the timeoutCycles-th WAIT cycle; cacheDone on that same edge takes precedence and timeoutError stays 0.

## Test plan
- Single L1 op: l1Op=0, l1Address=0x00001040, cacheDone 3 cycles after cacheValid rises → cacheSource=0, cacheOp=0, cacheAddress=0x00001040 held 3 cycles, l1Grants=1, next ready 1 cycle after done.
- Starvation: snoopValid and l1Valid held high continuously, starveLimit=4, done 1 cycle after each issue → grant order S,S,S,S,L,S,S,S,S,L; snoopGrants=8, l1Grants=2.
- Maintenance priority: maintValid, snoopValid and l1Valid raised together → maint issued first (cacheSource=2, cacheAddress=0), then snoop, then L1.
- Clear resets stats: after 3 L1 and 2 snoop grants, issue maintOp=0 and complete it → l1Grants=0, snoopGrants=0 on the done edge; maintOp=1 leaves the counters untouched.
- Watchdog: timeoutCycles=16, cacheDone never asserted → timeoutError=1 after 16 WAIT cycles, FSM in IDLE, next request accepted; a done at exactly cycle 16 leaves timeoutError=0.
- Reset mid-WAIT: resetN low for 1 cycle during WAIT → all outputs and counters 0, readies 0 during reset; a stale cacheDone after reset is ignored.
